// File: rtl/mips_16_hazard_scoreboard_if.sv
// Decode-stage hazard bus between the mips_16 ID stage and the hazard scoreboard.
//   master : ID stage, drives the decoded instruction fields, receives the
//            issue enable and the EX-stage operand forwarding selects.
//   slave  : hazard scoreboard.
// Signals:
//   id_valid                    decode holds a valid instruction
//   id_src1/2, id_src1/2_used   source register numbers and read flags
//   id_dest, id_dest_wr         destination register and write flag
//   id_is_load                  instruction is a load (result ready from stage 2)
//   stall_n                     1 = issue, 0 = hold IF/ID and insert a bubble
//   fwd_sel1/2                  0 = register file, k = result of stage k
interface mips_16_hazard_scoreboard_if #(
    parameter int unsigned REG_ADDR_WIDTH = 3,
    parameter int unsigned PIPE_DEPTH     = 3
);
    localparam int unsigned SEL_WIDTH = $clog2(PIPE_DEPTH + 1);

    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_src1;
    logic [REG_ADDR_WIDTH-1:0] id_src2;
    logic                      id_src1_used;
    logic                      id_src2_used;
    logic [REG_ADDR_WIDTH-1:0] id_dest;
    logic                      id_dest_wr;
    logic                      id_is_load;
    logic                      stall_n;
    logic [SEL_WIDTH-1:0]      fwd_sel1;
    logic [SEL_WIDTH-1:0]      fwd_sel2;

    modport master (
        output id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
               id_dest, id_dest_wr, id_is_load,
        input  stall_n, fwd_sel1, fwd_sel2
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
               id_dest, id_dest_wr, id_is_load,
        output stall_n, fwd_sel1, fwd_sel2
    );
endinterface

// File: rtl/mips_16_hazard_scoreboard.sv
// Hazard scoreboard and operand-forwarding controller for the mips_16 pipeline.
// Tracks {wr, dest, is_load} of every instruction in the PIPE_DEPTH stages
// after decode and derives the decode issue enable, the EX operand forwarding
// selects and a saturating stalled-cycle counter.
// Build option: define HAZARD_FORWARDING_EN to enable forwarding (only a
// load-use at stage 1 stalls); undefined gives the legacy behaviour where any
// in-flight writer of a used source stalls and the forwarding selects are 0.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   bus          decode hazard bus (slave side)
//   perf_clr     synchronous clear of stall_cycles (wins over increment)
//   stage_valid  bit k-1 = stage k holds a register-writing instruction
//   stage_dest   destination of stage k at slice k-1
//   stall_cycles saturating count of stalled decode cycles
module mips_16_hazard_scoreboard #(
    parameter int unsigned REG_ADDR_WIDTH = 3,
    parameter int unsigned PIPE_DEPTH     = 3,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    mips_16_hazard_scoreboard_if.slave           bus,
    input  logic                                 perf_clr,
    output logic [PIPE_DEPTH-1:0]                stage_valid,
    output logic [PIPE_DEPTH*REG_ADDR_WIDTH-1:0] stage_dest,
    output logic [CNT_WIDTH-1:0]                 stall_cycles
);
    localparam int unsigned SEL_WIDTH = $clog2(PIPE_DEPTH + 1);

    // Entry k-1 of each array describes pipeline stage k.
    logic [PIPE_DEPTH-1:0]                     wr_q;
    logic [PIPE_DEPTH-1:0][REG_ADDR_WIDTH-1:0] dest_q;
    logic [PIPE_DEPTH-1:0]                     load_q;

    logic [1:0][REG_ADDR_WIDTH-1:0] src;
    logic [1:0]                     used;
    logic [1:0]                     hit;
    logic [1:0]                     hit_load;
    logic [1:0][SEL_WIDTH-1:0]      hit_stage;
    logic [1:0]                     hazard;
    logic [1:0][SEL_WIDTH-1:0]      sel;
    logic                           issue;
    logic                           wr_in;
    logic [REG_ADDR_WIDTH-1:0]      dest_in;
    logic                           load_in;

    assign src[0]  = bus.id_src1;
    assign src[1]  = bus.id_src2;
    assign used[0] = bus.id_src1_used;
    assign used[1] = bus.id_src2_used;

    // Youngest matching in-flight writer per operand; register 0 never matches.
    always_comb begin
        hit       = '0;
        hit_load  = '0;
        hit_stage = '0;
        for (int unsigned o = 0; o < 2; o++) begin
            for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
                if (!hit[o] && used[o] && (src[o] != '0) && wr_q[k] &&
                    (dest_q[k] == src[o])) begin
                    hit[o]       = 1'b1;
                    hit_load[o]  = load_q[k];
                    hit_stage[o] = SEL_WIDTH'(k + 1);
                end
            end
        end
    end

`ifdef HAZARD_FORWARDING_EN
    // Only a load still in stage 1 cannot be forwarded; everything else bypasses.
    always_comb begin
        hazard = '0;
        sel    = '0;
        for (int unsigned o = 0; o < 2; o++) begin
            hazard[o] = hit[o] && hit_load[o] && (hit_stage[o] == SEL_WIDTH'(1));
        end
        for (int unsigned o = 0; o < 2; o++) begin
            if (issue && hit[o] && !hazard[o]) begin
                sel[o] = hit_stage[o];
            end
        end
    end
`else
    // Legacy core: any in-flight writer of a used source holds decode.
    always_comb begin
        hazard = hit;
        sel    = '0;
    end

    logic unused_fwd_info;
    assign unused_fwd_info = ^{hit_load, hit_stage, load_q};
`endif

    assign issue        = !(bus.id_valid && (|hazard));
    assign bus.stall_n  = issue;
    assign bus.fwd_sel1 = sel[0];
    assign bus.fwd_sel2 = sel[1];

    // New stage-1 entry: the issuing instruction, or a bubble when stalled/idle.
    always_comb begin
        wr_in   = 1'b0;
        dest_in = '0;
        load_in = 1'b0;
        if (bus.id_valid && issue) begin
            wr_in   = bus.id_dest_wr && (bus.id_dest != '0);
            dest_in = bus.id_dest;
            load_in = bus.id_is_load;
        end
    end

    // Shift register of in-flight destinations; oldest entry falls off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q   <= '0;
            dest_q <= '0;
            load_q <= '0;
        end else begin
            wr_q   <= {wr_q[PIPE_DEPTH-2:0], wr_in};
            dest_q <= {dest_q[PIPE_DEPTH-2:0], dest_in};
            load_q <= {load_q[PIPE_DEPTH-2:0], load_in};
        end
    end

    // Saturating stalled-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if (!issue && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

    assign stage_valid = wr_q;
    assign stage_dest  = dest_q;

endmodule

// File: tb/tb_mips_16_hazard_scoreboard.sv
// Self-checking bench for mips_16_hazard_scoreboard (REG_ADDR_WIDTH=3,
// PIPE_DEPTH=3). A second instance with CNT_WIDTH=2 shares the stimulus to
// exercise counter saturation. Expected values follow HAZARD_FORWARDING_EN.
module tb_mips_16_hazard_scoreboard;
    localparam int unsigned RAW = 3;
    localparam int unsigned PD  = 3;
    localparam int unsigned SW  = $clog2(PD + 1);

`ifdef HAZARD_FORWARDING_EN
    localparam int STALL_LU     = 1;
    localparam int TABLE_STALLS = 1;
`else
    localparam int STALL_LU     = 3;
    localparam int TABLE_STALLS = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    logic perf_clr;
    logic [PD-1:0]     stage_valid, stage_valid_s;
    logic [PD*RAW-1:0] stage_dest, stage_dest_s;
    logic [15:0]       stall_cycles;
    logic [1:0]        stall_cycles_s;

    always #5 clk = ~clk;

    mips_16_hazard_scoreboard_if #(.REG_ADDR_WIDTH(RAW), .PIPE_DEPTH(PD)) bus ();
    mips_16_hazard_scoreboard_if #(.REG_ADDR_WIDTH(RAW), .PIPE_DEPTH(PD)) bus_s ();

    assign bus_s.id_valid     = bus.id_valid;
    assign bus_s.id_src1      = bus.id_src1;
    assign bus_s.id_src2      = bus.id_src2;
    assign bus_s.id_src1_used = bus.id_src1_used;
    assign bus_s.id_src2_used = bus.id_src2_used;
    assign bus_s.id_dest      = bus.id_dest;
    assign bus_s.id_dest_wr   = bus.id_dest_wr;
    assign bus_s.id_is_load   = bus.id_is_load;

    mips_16_hazard_scoreboard #(.REG_ADDR_WIDTH(RAW), .PIPE_DEPTH(PD), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .perf_clr(perf_clr),
        .stage_valid(stage_valid), .stage_dest(stage_dest), .stall_cycles(stall_cycles)
    );

    mips_16_hazard_scoreboard #(.REG_ADDR_WIDTH(RAW), .PIPE_DEPTH(PD), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus_s), .perf_clr(perf_clr),
        .stage_valid(stage_valid_s), .stage_dest(stage_dest_s), .stall_cycles(stall_cycles_s)
    );

    typedef struct {
        logic          v;
        logic [RAW-1:0] s1;
        logic          u1;
        logic [RAW-1:0] s2;
        logic          u2;
        logic [RAW-1:0] d;
        logic          w;
        logic          l;
        logic          sn;
        logic [SW-1:0] f1;
        logic [SW-1:0] f2;
    } vec_t;

    typedef struct {
        logic          sn;
        logic [SW-1:0] f1;
        logic [SW-1:0] f2;
    } exp_t;

    vec_t vt[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input int v, input int s1, input int u1, input int s2,
                                input int u2, input int d, input int w, input int l,
                                input int sn, input int f1, input int f2);
        vec_t t;
        t.v  = 1'(v);   t.s1 = RAW'(s1); t.u1 = 1'(u1);
        t.s2 = RAW'(s2); t.u2 = 1'(u2);  t.d  = RAW'(d);
        t.w  = 1'(w);   t.l  = 1'(l);    t.sn = 1'(sn);
        t.f1 = SW'(f1); t.f2 = SW'(f2);
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t t);
        bus.id_valid     = t.v;
        bus.id_src1      = t.s1;
        bus.id_src1_used = t.u1;
        bus.id_src2      = t.s2;
        bus.id_src2_used = t.u2;
        bus.id_dest      = t.d;
        bus.id_dest_wr   = t.w;
        bus.id_is_load   = t.l;
    endtask

    task automatic idle(input int n);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        perf_clr = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the current instruction until it issues; counts stalled cycles.
    task automatic run_until_issue(input int budget, output int stalls, output bit ok);
        int c;
        stalls = 0;
        ok     = 1'b0;
        c      = 0;
        while (!ok && c < budget) begin
            @(negedge clk);
            if (bus.stall_n) ok = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   st;
        bit   ok;

`ifdef HAZARD_FORWARDING_EN
        vt.push_back(mk(1,1,1,3,1,2,1,0, 1,0,0)); // ADD r2
        vt.push_back(mk(1,4,1,2,1,5,1,0, 1,0,1)); // user r2 at stage 1
        vt.push_back(mk(1,6,1,2,1,4,1,0, 1,0,2)); // user r2 at stage 2
        vt.push_back(mk(1,0,1,0,0,3,1,1, 1,0,0)); // LW r3
        vt.push_back(mk(1,3,1,5,1,6,1,0, 0,0,0)); // load-use stall
        vt.push_back(mk(1,3,1,5,1,6,1,0, 1,2,0)); // forwarded from stage 2
        vt.push_back(mk(1,6,1,3,1,7,1,0, 1,1,3)); // operands at different stages
        vt.push_back(mk(1,0,0,0,0,7,1,0, 1,0,0)); // second writer of r7
        vt.push_back(mk(1,7,1,6,1,1,0,0, 1,1,3)); // youngest r7 wins
        vt.push_back(mk(1,0,0,0,0,0,1,0, 1,0,0)); // dest r0 producer
        vt.push_back(mk(1,1,1,0,1,2,1,0, 1,0,0)); // r1 had wr=0, r0 source
        vt.push_back(mk(1,0,0,0,0,4,1,1, 1,0,0)); // LW r4
        vt.push_back(mk(0,4,1,0,0,0,0,0, 1,0,0)); // invalid: no stall
        vt.push_back(mk(1,4,1,2,1,5,1,0, 1,2,3)); // load at stage 2 forwards
`else
        vt.push_back(mk(1,2,1,3,1,1,1,0, 1,0,0)); // ADD r1
        vt.push_back(mk(1,1,1,4,1,5,1,0, 0,0,0)); // SUB r1: stage 1
        vt.push_back(mk(1,1,1,4,1,5,1,0, 0,0,0)); // stage 2
        vt.push_back(mk(1,1,1,4,1,5,1,0, 0,0,0)); // stage 3
        vt.push_back(mk(1,1,1,4,1,5,1,0, 1,0,0)); // issues
        vt.push_back(mk(1,0,0,0,0,0,1,0, 1,0,0)); // dest r0 producer
        vt.push_back(mk(1,0,1,0,1,6,1,0, 1,0,0)); // r0 sources never hazard
        vt.push_back(mk(1,2,1,2,1,7,0,0, 1,0,0)); // producer with wr=0
        vt.push_back(mk(1,7,1,7,1,1,1,0, 1,0,0)); // user of r7 (not written)
        vt.push_back(mk(1,1,0,6,0,2,0,0, 1,0,0)); // unused operands
        vt.push_back(mk(0,1,1,0,0,0,0,0, 1,0,0)); // invalid: no stall
        vt.push_back(mk(1,1,1,3,1,3,1,0, 0,0,0)); // r1 in stage 3
        vt.push_back(mk(1,1,1,3,1,3,1,0, 1,0,0)); // r1 dropped: issues
`endif

        // Reset with a valid instruction presented.
        perf_clr = 1'b0;
        rst      = 1'b0;
        drive(mk(1,1,1,2,1,3,1,1, 1,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall_n", 32'(bus.stall_n), 32'd1);
        check("reset fwd_sel1", 32'(bus.fwd_sel1), 32'd0);
        check("reset fwd_sel2", 32'(bus.fwd_sel2), 32'd0);
        check("reset stall_cycles", 32'(stall_cycles), 32'd0);
        check("reset stage_valid", 32'(stage_valid), 32'd0);
        check("reset stage_dest", 32'(stage_dest), 32'd0);
        drive(mk(0,0,0,0,0,0,0,0, 1,0,0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors through the scoreboard queue.
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i]);
            exp_q.push_back('{vt[i].sn, vt[i].f1, vt[i].f2});
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("vec%0d stall_n", i), 32'(bus.stall_n), 32'(e.sn));
            check($sformatf("vec%0d fwd_sel1", i), 32'(bus.fwd_sel1), 32'(e.f1));
            check($sformatf("vec%0d fwd_sel2", i), 32'(bus.fwd_sel2), 32'(e.f2));
            @(posedge clk);
            #1;
        end
        check("table stall_cycles", 32'(stall_cycles), 32'(TABLE_STALLS));
        idle(4);

        // Stage visibility and perf_clr during a stall.
        drive(mk(1,0,0,0,0,3,1,1, 1,0,0));
        @(posedge clk);
        #1;
        drive(mk(1,3,1,0,0,6,1,0, 0,0,0));
        perf_clr = 1'b1;
        @(negedge clk);
        check("lu stall_n", 32'(bus.stall_n), 32'd0);
        check("lw stage_valid", 32'(stage_valid), 32'd1);
        check("lw stage_dest", 32'(stage_dest), 32'd3);
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        check("perf_clr stall_cycles", 32'(stall_cycles), 32'd0);
        check("perf_clr stall_cycles_s", 32'(stall_cycles_s), 32'd0);
        run_until_issue(10, st, ok);
        check("lu issue timeout", 32'(ok), 32'd1);
        check("lu remaining stalls", 32'(st), 32'(STALL_LU - 1));
        drive(mk(0,0,0,0,0,0,0,0, 1,0,0));
        check("after clr stall_cycles", 32'(stall_cycles), 32'(STALL_LU - 1));
        idle(4);

        // Saturation of the 2-bit counter across repeated load-use pairs.
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        check("clr stall_cycles_s", 32'(stall_cycles_s), 32'd0);
        for (int r = 0; r < 5; r++) begin
            drive(mk(1,0,0,0,0,3,1,1, 1,0,0));
            @(posedge clk);
            #1;
            drive(mk(1,3,1,0,0,6,1,0, 0,0,0));
            run_until_issue(10, st, ok);
            check($sformatf("sat rep%0d stalls", r), 32'(st), 32'(STALL_LU));
        end
        drive(mk(0,0,0,0,0,0,0,0, 1,0,0));
        check("sat stall_cycles", 32'(stall_cycles), 32'(5 * STALL_LU));
        check("sat stall_cycles_s", 32'(stall_cycles_s), 32'd3);
        idle(4);

        // Asynchronous reset in the middle of a stall.
        drive(mk(1,0,0,0,0,1,1,1, 1,0,0));
        @(posedge clk);
        #1;
        drive(mk(1,1,1,1,1,2,1,0, 0,0,0));
        @(negedge clk);
        check("pre-reset stall_n", 32'(bus.stall_n), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("async reset stall_n", 32'(bus.stall_n), 32'd1);
        check("async reset fwd_sel1", 32'(bus.fwd_sel1), 32'd0);
        check("async reset stage_valid", 32'(stage_valid), 32'd0);
        check("async reset stall_cycles", 32'(stall_cycles), 32'd0);
        drive(mk(0,0,0,0,0,0,0,0, 1,0,0));
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mips_16_hazard_scoreboard.md
# mips_16_hazard_scoreboard

Parametrised hazard scoreboard and operand-forwarding controller for the mips_16 pipeline; it replaces the purely combinational stall check of the current core. It tracks the destination register of every in-flight instruction after decode in an internal shift register of `PIPE_DEPTH` stages. From this it produces the decode-stage issue enable (`stall_n`), per-operand forwarding selects and a saturating stall-cycle counter. It sits beside the ID stage and drives the IF/ID enable and the EX-stage operand muxes.

## Interface
- `REG_ADDR_WIDTH`, 3, register-number width; register 0 is hard-wired zero.
- `PIPE_DEPTH`, 3, tracked stages after decode: stage 1 = EX, 2 = MEM, …, `PIPE_DEPTH` = WB; legal 2..7.
- `CNT_WIDTH`, 16, stall counter width.
- `SEL_WIDTH`, derived = clog2(`PIPE_DEPTH`+1), forwarding-select width.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode holds a valid instruction.
- `id_src1`, `id_src2` in `REG_ADDR_WIDTH`: source register numbers.
- `id_src1_used`, `id_src2_used` in 1: the operand is actually read.
- `id_dest` in `REG_ADDR_WIDTH`: destination register number.
- `id_dest_wr` in 1: the instruction writes `id_dest`.
- `id_is_load` in 1: the instruction is a load; its result is available from stage 2.
- `perf_clr` in 1: synchronous clear of `stall_cycles`.
- `stall_n` out 1: 1 = issue the decode instruction; 0 = hold IF/ID and insert a bubble.
- `fwd_sel1`, `fwd_sel2` out `SEL_WIDTH`: 0 = register file; k = result of stage k.
- `stage_valid` out `PIPE_DEPTH`: bit k-1 = stage k holds a register-writing instruction.
- `stage_dest` out `PIPE_DEPTH`*`REG_ADDR_WIDTH`: dest of stage k at slice k-1.
- `stall_cycles` out `CNT_WIDTH`: saturating count of stalled cycles.

## Operation
- Each entry holds {wr, dest, is_load}.
  - Entry 1 loads {`id_dest_wr` & (`id_dest`≠0), `id_dest`, `id_is_load`} when `id_valid` & `stall_n`; otherwise it loads a bubble (all zero).
  - Entry k loads entry k-1 for k ≥ 2.
  - The oldest entry is dropped.
- A match for an operand: the operand is used, the source is ≠0, and some entry has wr=1 and dest=source. The youngest match (smallest k) has priority.
- `stall_n` = 0 only when `id_valid`=1 and at least one used operand hazards. With `id_valid`=0, `stall_n`=1.
- The instruction's own `id_dest` never hazards against its own sources.
- `fwd_sel` is meaningful only when `stall_n`=1; otherwise it is 0.
- `stall_cycles` increments each cycle `id_valid` & ~`stall_n` and saturates at all-ones. `perf_clr` wins over increment.
- `branch_taken` is not an input: the single delay slot is issued normally, and nothing is flushed.

## Timing
- `stall_n`, `fwd_sel*` are combinational from the current entries and the ID inputs, in the same cycle. The entries and counter update on the rising `clk` edge.
- A stalled instruction re-evaluates every cycle. It issues in the first cycle its hazard clears.
- Reset values:
  - all entries invalid, so `stage_valid`=0 and `stage_dest`=0;
  - `stall_cycles`=0;
  - therefore `stall_n`=1 and `fwd_sel*`=0 while in reset and after reset.
- Reset mid-stall: entries and counter clear immediately, and `stall_n` goes high asynchronously.
- A dependent instruction immediately after its producer stalls at most `PIPE_DEPTH` cycles without forwarding. With forwarding it stalls 1 cycle on load-use and 0 otherwise.

## Configuration
- `HAZARD_FORWARDING_EN` defined:
  - the hazard condition is youngest match at stage 1 with is_load=1 (load-use), giving a stall;
  - any other youngest match at stage k sets `fwd_sel`=k.
- `HAZARD_FORWARDING_EN` undefined:
  - any match in stages 1..`PIPE_DEPTH` stalls;
  - `fwd_sel1`/`fwd_sel2` are constant 0;
  - this is the legacy no-forwarding behaviour.

## Test plan
- Reset: hold `rst`=0 with `id_valid`=1 and arbitrary sources → `stall_n`=1, `fwd_sel*`=0, `stall_cycles`=0, `stage_valid`=0.
- No forwarding, `PIPE_DEPTH`=3: issue ADD r1, then SUB with src1=r1 → `stall_n`=0 for 3 cycles, then issue; `stall_cycles`=3.
- `HAZARD_FORWARDING_EN`: ADD r2, then an instruction using src2=r2 → `stall_n`=1, `fwd_sel2`=1. After an independent instruction, a user of r2 → `fwd_sel2`=2.
- `HAZARD_FORWARDING_EN`: LW r3, then a user of r3 → exactly 1 stall cycle, then issue with `fwd_sel1`=2.
- Producer with `id_dest`=0, or `id_dest_wr`=0, followed by a user of that register → never stalls, `fwd_sel`=0. Both operands matching different stages → each select picks its own youngest match.
- `CNT_WIDTH`=2: force 5 consecutive stall cycles → `stall_cycles` sticks at 3. Assert `perf_clr` during a stall → 0 on the next edge.
